// File: rtl/uart_program_loader.sv
// UART 8N1 receiver that fills a 32-byte program memory while Load is high.
// The program memory is read back through a registered port addressed by PC.
module uart_program_loader #(
    parameter int CLK_FREQ = 100000000,
    parameter int Baudrate = 9600
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic       RX,
    input  logic [4:0] PC,
    output logic [7:0] data_out,
    output logic       FE,
    output logic [5:0] Byte_count,
    output logic       Full
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / Baudrate;
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [5:0]  MEM_DEPTH    = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  idx_reg, idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic        rx_meta_reg, rx_sync_reg;
    logic        load_prev_reg;
    logic [5:0]  byte_count_reg;
    logic        fe_reg;
    logic [7:0]  data_out_reg;
    logic [7:0]  mem_reg [32];

    logic        byte_valid;
    logic        frame_err;
    logic        load_rise;
    logic        full;
    logic        wr_en;
    logic [31:0] wr_sel;

    assign load_rise  = Load && !load_prev_reg;
    assign full       = (byte_count_reg == MEM_DEPTH);
    // A load restart in the same cycle as a completed byte discards the byte.
    assign wr_en      = byte_valid && !full && !load_rise;

    assign data_out   = data_out_reg;
    assign FE         = fe_reg;
    assign Byte_count = byte_count_reg;
    assign Full       = full;

    // RX is asynchronous; only the second flop is ever looked at.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rx_meta_reg   <= 1'b1;
            rx_sync_reg   <= 1'b1;
            load_prev_reg <= 1'b0;
        end else begin
            rx_meta_reg   <= RX;
            rx_sync_reg   <= rx_meta_reg;
            load_prev_reg <= Load;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 16'd0;
            idx_reg   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (!Load && state_reg != S_IDLE) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (Load && !rx_sync_reg) begin
                        state_next = S_START;
                        cnt_next   = 16'd0;
                    end
                end
                S_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        if (!rx_sync_reg) begin
                            state_next = S_DATA;
                            cnt_next   = 16'd0;
                            idx_next   = 3'd0;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_next   = 16'd0;
                        shift_next = {rx_sync_reg, shift_reg[7:1]};
                        if (idx_reg == 3'd7) begin
                            state_next = S_STOP;
                        end else begin
                            idx_next = idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_next = 16'd0;
                        if (rx_sync_reg) begin
                            byte_valid = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            frame_err  = 1'b1;
                            state_next = S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_sync_reg) begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            byte_count_reg <= 6'd0;
            fe_reg         <= 1'b0;
        end else if (load_rise) begin
            byte_count_reg <= 6'd0;
            fe_reg         <= 1'b0;
        end else begin
            if (byte_valid && !full) begin
                byte_count_reg <= byte_count_reg + 6'd1;
            end
            if (frame_err) begin
                fe_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (byte_count_reg[4:0] == 5'(gi));
        end
    endgenerate

    // Every entry must clear on reset, so the memory is kept in registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_reg[i] <= 8'd0;
            end
            data_out_reg <= 8'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= shift_reg;
                end
            end
            data_out_reg <= mem_reg[PC];
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed self-checking bench for uart_program_loader at 16 clocks per bit.
module tb_uart_program_loader;

    logic       Clk;
    logic       Reset;
    logic       Load;
    logic       RX;
    logic [4:0] PC;
    logic [7:0] data_out;
    logic       FE;
    logic [5:0] Byte_count;
    logic       Full;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [4:0] pc;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t rd_vec [6];

    uart_program_loader #(
        .CLK_FREQ(16),
        .Baudrate(1)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Load(Load),
        .RX(RX),
        .PC(PC),
        .data_out(data_out),
        .FE(FE),
        .Byte_count(Byte_count),
        .Full(Full)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Start bit, nbits data bits LSB first, optional stop bit, then idle high.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit with_stop,
                              input logic stop_val);
        RX = 1'b0;
        tick(16);
        for (int i = 0; i < nbits; i++) begin
            RX = d[i];
            tick(16);
        end
        if (with_stop) begin
            RX = stop_val;
            tick(16);
        end
        RX = 1'b1;
        tick(4);
    endtask

    task automatic read_at(input string name, input logic [4:0] addr, input logic [7:0] exp);
        PC = addr;
        tick(1);
        check(name, {24'd0, data_out}, {24'd0, exp});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        Load     = 1'b0;
        RX       = 1'b1;
        PC       = 5'd0;

        rd_vec[0] = '{pc: 5'd0,  exp: 8'hA5};
        rd_vec[1] = '{pc: 5'd1,  exp: 8'h3C};
        rd_vec[2] = '{pc: 5'd2,  exp: 8'h00};
        rd_vec[3] = '{pc: 5'd31, exp: 8'h1F};
        rd_vec[4] = '{pc: 5'd0,  exp: 8'h00};
        rd_vec[5] = '{pc: 5'd30, exp: 8'h1E};

        tick(3);
        check("reset data_out", {24'd0, data_out}, 32'h0);
        check("reset FE", {31'd0, FE}, 32'd0);
        check("reset Byte_count", {26'd0, Byte_count}, 32'd0);
        check("reset Full", {31'd0, Full}, 32'd0);
        Reset = 1'b0;
        tick(2);

        // Two good bytes, then read them back in run mode.
        Load = 1'b1;
        tick(2);
        send_frame(8'hA5, 8, 1'b1, 1'b1);
        send_frame(8'h3C, 8, 1'b1, 1'b1);
        check("two bytes Byte_count", {26'd0, Byte_count}, 32'd2);
        check("two bytes FE", {31'd0, FE}, 32'd0);
        Load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            read_at($sformatf("read pc=%0d", rd_vec[i].pc), rd_vec[i].pc, rd_vec[i].exp);
        end

        // Short low glitch on an idle line must not start a frame.
        Load = 1'b1;
        tick(2);
        check("load rise clears count", {26'd0, Byte_count}, 32'd0);
        RX = 1'b0;
        tick(4);
        RX = 1'b1;
        tick(40);
        check("glitch Byte_count", {26'd0, Byte_count}, 32'd0);
        check("glitch FE", {31'd0, FE}, 32'd0);

        // Overfill: 33 bytes, the last one discarded without wrapping.
        for (int b = 0; b < 33; b++) begin
            send_frame(8'(b), 8, 1'b1, 1'b1);
        end
        check("overfill Byte_count", {26'd0, Byte_count}, 32'd32);
        check("overfill Full", {31'd0, Full}, 32'd1);
        check("overfill FE", {31'd0, FE}, 32'd0);
        Load = 1'b0;
        for (int i = 3; i < 6; i++) begin
            read_at($sformatf("full read pc=%0d", rd_vec[i].pc), rd_vec[i].pc, rd_vec[i].exp);
        end

        // Framing error, sticky FE, recovery, and clear on load restart.
        Load = 1'b1;
        tick(2);
        check("restart Full", {31'd0, Full}, 32'd0);
        send_frame(8'h55, 8, 1'b1, 1'b0);
        check("frame err FE", {31'd0, FE}, 32'd1);
        check("frame err Byte_count", {26'd0, Byte_count}, 32'd0);
        send_frame(8'h77, 8, 1'b1, 1'b1);
        check("after ferr Byte_count", {26'd0, Byte_count}, 32'd1);
        check("FE sticky", {31'd0, FE}, 32'd1);
        read_at("after ferr pc=0", 5'd0, 8'h77);
        Load = 1'b0;
        tick(2);
        Load = 1'b1;
        tick(2);
        check("reload FE cleared", {31'd0, FE}, 32'd0);
        check("reload count cleared", {26'd0, Byte_count}, 32'd0);

        // Dropping Load mid-frame discards the partial byte.
        send_frame(8'h11, 8, 1'b1, 1'b1);
        send_frame(8'h81, 4, 1'b0, 1'b1);
        Load = 1'b0;
        tick(200);
        check("abort Byte_count", {26'd0, Byte_count}, 32'd1);
        check("abort FE", {31'd0, FE}, 32'd0);
        read_at("abort pc=1 untouched", 5'd1, 8'h01);
        Load = 1'b1;
        tick(2);
        send_frame(8'h81, 8, 1'b1, 1'b1);
        check("resend Byte_count", {26'd0, Byte_count}, 32'd1);
        read_at("resend pc=0", 5'd0, 8'h81);

        // Reset during data bit 5 clears everything and writes nothing.
        send_frame(8'hC3, 5, 1'b0, 1'b1);
        Reset = 1'b1;
        tick(1);
        check("midreset data_out", {24'd0, data_out}, 32'h0);
        check("midreset FE", {31'd0, FE}, 32'd0);
        check("midreset Byte_count", {26'd0, Byte_count}, 32'd0);
        check("midreset Full", {31'd0, Full}, 32'd0);
        Reset = 1'b0;
        tick(200);
        check("post reset Byte_count", {26'd0, Byte_count}, 32'd0);
        read_at("post reset pc=0", 5'd0, 8'h00);
        read_at("post reset pc=1", 5'd1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 CLK_FREQ, 100000000, Clk frequency in Hz.
REQ-002 Baudrate, 9600, serial bit rate; CLKS_PER_BIT = CLK_FREQ/Baudrate (integer division), legal range 4..65535.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Load  input  1  high = loading mode, receiver enabled; low = run mode, receiver idle.
REQ-006 RX  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-007 PC  input  5  program read address.
REQ-008 data_out  output  8  registered program byte at PC.
REQ-009 FE  output  1  sticky framing-error flag.
REQ-010 Byte_count  output  6  bytes stored since last load start, 0..32.
REQ-011 Full  output  1  high when Byte_count == 32.

Function
REQ-012 RX passes through a 2-flop synchronizer before any use; 2-cycle added latency is accepted.
REQ-013 Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE -> START when Load==1 and synchronized RX==0; baud counter cleared.
REQ-015 START: at count CLKS_PER_BIT/2-1 sample RX; 0 -> DATA (counter cleared, bit index 0); 1 -> IDLE (glitch, nothing stored).
REQ-016 DATA: sample RX every CLKS_PER_BIT cycles into shift register, LSB first; after bit index 7 -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles sample RX; 1 -> byte valid, IDLE; 0 -> FE set, byte discarded, WAIT_HIGH.
REQ-018 WAIT_HIGH -> IDLE on first cycle synchronized RX==1.
REQ-019 Valid byte with Full==0: written to mem[Byte_count[4:0]] and Byte_count incremented in the same cycle as the STOP sample.
REQ-020 Valid byte with Full==1: discarded; Byte_count holds at 32, no wrap-around; FE unaffected.
REQ-021 Load rising edge (Load==1, previous Load==0): Byte_count cleared to 0 and FE cleared; memory contents retained until overwritten.
REQ-022 Load==0 in any non-IDLE state: FSM -> IDLE next cycle, partial byte discarded, no write, no FE.
REQ-023 Load rising edge coinciding with valid-byte completion: the clear wins; byte not stored.
REQ-024 Program memory: 32 x 8 registers, one write port (receiver), one read port.
REQ-025 data_out <= mem[PC] every cycle, 1-cycle latency; a write and a read to the same address in one cycle returns the old data.
REQ-026 data_out updates regardless of Load.

Reset
REQ-027 On Reset==1 at a rising Clk: FSM=IDLE, counters=0, shift register=0, Byte_count=0, Full=0, FE=0, data_out=0x00, all 32 memory entries=0x00, synchronizer flops=1, previous-Load register=0.
REQ-028 Reset mid-frame aborts the frame with no write; Reset has priority over every other event in the same cycle.

Verification (CLK_FREQ=16, Baudrate=1, so CLKS_PER_BIT=16)
REQ-029 Reset, Load=1, send 0xA5, 0x3C, Load=0, PC=0 then PC=1 -> data_out=0xA5, then 0x3C one cycle after each PC change; Byte_count=2, FE=0.
REQ-030 Send 33 bytes 0x00..0x20 under Load=1 -> Full=1, Byte_count=32; mem[31]=0x1F; 0x20 not stored; mem[0]=0x00 unchanged.
REQ-031 Send 0x55 with stop bit forced 0 -> FE=1, Byte_count unchanged; next good byte 0x77 is stored after RX returns high; Load low->high clears FE and Byte_count.
REQ-032 RX low pulse of 4 cycles while idle -> no frame; Byte_count=0, FE=0.
REQ-033 Drop Load after data bit 3 of 0x81 -> no write, Byte_count unchanged; reassert Load and send 0x81 -> stored at address 0.
REQ-034 Assert Reset during data bit 5 -> all outputs at reset values the next cycle; no memory write.
